// File: rtl/saved_reg_cell.sv
// Single enabled storage register used for the saved-register slots of the two-bank register file.
// Loads din on a rising clk edge when en is high; reset is asynchronous and active-low.
module saved_reg_cell #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    always_comb begin
        dout_d = dout_q;
        if (en) begin
            dout_d = din;
        end
    end

    // Reset clears the cell immediately and keeps it at RESET_VALUE while held low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= RESET_VALUE;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_saved_reg_cell.sv
// Directed bench for saved_reg_cell: expected values are queued when stimulus is applied
// and popped for comparison once the DUT output is due.
module tb_saved_reg_cell;

    localparam int WIDTH = 10;

    logic             clk;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    logic [WIDTH-1:0] exp_q[$];
    string            tag_q[$];
    int               vectors;
    int               miscompares;

    saved_reg_cell #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(10'd0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare();
        logic [WIDTH-1:0] exp;
        string            t;
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        vectors++;
        assert (dout === exp) else begin
            miscompares++;
            $error("FAIL %s: dout=%0d expected=%0d", t, dout, exp);
        end
    endtask

    // Compare against the current output without waiting for a clock edge.
    task automatic check_now(input string tag, input logic [WIDTH-1:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        compare();
    endtask

    // Drive en/din on the falling edge, compare just after the following rising edge.
    task automatic do_edge(input string tag, input logic e, input logic [WIDTH-1:0] d,
                           input logic [WIDTH-1:0] exp);
        @(negedge clk);
        en  = e;
        din = d;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        logic [WIDTH-1:0] last;
        logic [WIDTH-1:0] r;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        en    = 1'b1;
        din   = 10'd55;

        #2;
        check_now("reset_immediate", 10'd0);
        for (int i = 0; i < 3; i++) begin
            do_edge("reset_hold", 1'b1, 10'd55, 10'd0);
        end

        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        din   = 10'd55;
        #1;
        check_now("pre_load", 10'd0);
        exp_q.push_back(10'd55);
        tag_q.push_back("first_load");
        @(posedge clk);
        #1;
        compare();

        for (int i = 0; i < 3; i++) begin
            do_edge("hold", 1'b0, 10'd10, 10'd55);
        end

        do_edge("b2b_load0", 1'b1, 10'd100, 10'd100);
        do_edge("b2b_load1", 1'b1, 10'd150, 10'd150);

        do_edge("all_ones",  1'b1, 10'h3FF, 10'd1023);
        do_edge("all_zeros", 1'b1, 10'h000, 10'd0);
        do_edge("alt_a",     1'b1, 10'h2AA, 10'h2AA);
        do_edge("alt_5",     1'b1, 10'h155, 10'h155);

        last = 10'h155;
        for (int i = 0; i < 6; i++) begin
            r = WIDTH'($urandom_range(0, 1023));
            if (i % 2 == 0) begin
                do_edge("rand_load", 1'b1, r, r);
                last = r;
            end else begin
                do_edge("rand_hold", 1'b0, r, last);
            end
        end

        do_edge("pre_midreset", 1'b1, 10'd150, 10'd150);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
        din   = 10'd77;
        #1;
        check_now("midreset_async", 10'd0);
        exp_q.push_back(10'd0);
        tag_q.push_back("midreset_pending_ignored");
        @(posedge clk);
        #1;
        compare();

        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        din   = 10'd99;
        exp_q.push_back(10'd0);
        tag_q.push_back("release_en_low");
        @(posedge clk);
        #1;
        compare();

        do_edge("post_reset_load", 1'b1, 10'd321, 10'd321);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
